dm_port_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters:
  - the CPU memory stage (word-aligned address, byte enables already formed);
  - a secondary DMA/debug requester.
- Sequences each access through a fixed-latency memory: latch request, hold address for WAIT_CYCLES, issue a one-cycle write strobe, sample read data, return a response.
- Drives the CPU pipeline stall and the DMA acknowledge.

---
 rtl/dm_port_arbiter_pkg.sv | 30 +++
 rtl/dm_port_arbiter_if.sv | 44 ++++
 rtl/dm_port_arbiter.sv | 112 +++++++++++
 tb/tb_dm_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared encodings for the data-memory port arbiter: FSM states, grant
// owner and the byte-enable pattern that marks a read.
package dm_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_DMA = 1'b1
   } grant_t;

   localparam logic [3:0] BYTEEN_READ = 4'b0000;

   // A lone requester wins outright; on a tie the requester that did not
   // win last time gets the port.
   function automatic grant_t pick_grant(input logic cpu, input logic dma,
                                         input grant_t last);
      if (cpu && dma)
         return (last == GNT_CPU) ? GNT_DMA : GNT_CPU;
      else if (dma)
         return GNT_DMA;
      else
         return GNT_CPU;
   endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the CPU request, DMA request and memory port signals seen by
// the data-memory arbiter. The master side is the arbiter (it masters the
// memory port); the slave side is the surrounding CPU/DMA/memory.
interface dm_port_arbiter_if;

   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_byteen;
   logic [31:0] cpu_rdata;
   logic        cpu_done;
   logic        cpu_stall;

   logic        dma_req;
   logic [31:0] dma_addr;
   logic [31:0] dma_wdata;
   logic [3:0]  dma_byteen;
   logic [31:0] dma_rdata;
   logic        dma_ack;

   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_data_rdata;

   modport master (
      input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
      output cpu_rdata, cpu_done, cpu_stall,
      input  dma_req, dma_addr, dma_wdata, dma_byteen,
      output dma_rdata, dma_ack,
      output m_data_addr, m_data_wdata, m_data_byteen,
      input  m_data_rdata
   );

   modport slave (
      output cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
      input  cpu_rdata, cpu_done, cpu_stall,
      output dma_req, dma_addr, dma_wdata, dma_byteen,
      input  dma_rdata, dma_ack,
      input  m_data_addr, m_data_wdata, m_data_byteen,
      output m_data_rdata
   );

endinterface

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares one fixed-latency memory port between
// the CPU memory stage and a DMA/debug requester, round-robin on ties.
// Each access is IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP.
// Optional macro DM_ARB_PERF_CNT_EN adds saturating stall/grant counters.
module dm_port_arbiter
   import dm_port_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   dm_port_arbiter_if.master    bus
`ifdef DM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]          perf_cpu_stall_cnt,
   output logic [31:0]          perf_dma_grant_cnt
`endif
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   state_t            state, next_state;
   grant_t            grant, last_grant, sel;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       addr_q, wdata_q;
   logic [3:0]        byteen_q;
   logic [31:0]       cpu_rdata_q, dma_rdata_q;
   logic              req_any, strobe_cyc;

   // Byte-offset bits are dropped on the word-aligned memory address.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^addr_q[1:0];

   assign req_any    = bus.cpu_req | bus.dma_req;
   assign sel        = pick_grant(bus.cpu_req, bus.dma_req, last_grant);
   assign strobe_cyc = (state == ST_ACCESS) && (cnt == '0);

   // Next-state logic; arbitration only ever happens in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (req_any) next_state = ST_ACCESS;
         ST_ACCESS: if (cnt == '0) next_state = ST_RESP;
         ST_RESP:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // State, grant latch, wait counter and read-data capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant       <= GNT_CPU;
         last_grant  <= GNT_DMA;
         cnt         <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         byteen_q    <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state <= next_state;
         if (state == ST_IDLE && req_any) begin
            grant      <= sel;
            last_grant <= sel;
            cnt        <= CNT_W'(WAIT_CYCLES);
            if (sel == GNT_CPU) begin
               addr_q   <= bus.cpu_addr;
               wdata_q  <= bus.cpu_wdata;
               byteen_q <= bus.cpu_byteen;
            end else begin
               addr_q   <= bus.dma_addr;
               wdata_q  <= bus.dma_wdata;
               byteen_q <= bus.dma_byteen;
            end
         end
         if (state == ST_ACCESS && cnt != '0)
            cnt <= cnt - CNT_W'(1);
         if (strobe_cyc && byteen_q == BYTEEN_READ) begin
            if (grant == GNT_CPU) cpu_rdata_q <= bus.m_data_rdata;
            else                  dma_rdata_q <= bus.m_data_rdata;
         end
      end
   end

   assign bus.m_data_addr   = {addr_q[31:2], 2'b00};
   assign bus.m_data_wdata  = wdata_q;
   assign bus.m_data_byteen = strobe_cyc ? byteen_q : BYTEEN_READ;

   assign bus.cpu_done  = (state == ST_RESP) && (grant == GNT_CPU);
   assign bus.dma_ack   = (state == ST_RESP) && (grant == GNT_DMA);
   assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;

`ifdef DM_ARB_PERF_CNT_EN
   // Saturating counters for CPU stall cycles and DMA grants.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cpu_stall_cnt <= '0;
         perf_dma_grant_cnt <= '0;
      end else begin
         if (bus.cpu_stall && perf_cpu_stall_cnt != 32'hFFFF_FFFF)
            perf_cpu_stall_cnt <= perf_cpu_stall_cnt + 32'd1;
         if (state == ST_IDLE && req_any && sel == GNT_DMA &&
             perf_dma_grant_cnt != 32'hFFFF_FFFF)
            perf_dma_grant_cnt <= perf_dma_grant_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter. Three instances cover WAIT_CYCLES of
// 1, 0 and 3; each scenario task drives one of them and checks inline.
module tb_dm_port_arbiter;

   logic clk;
   logic rst1, rst0, rst3;
   int   checks;
   int   errors;

   dm_port_arbiter_if b1 ();
   dm_port_arbiter_if b0 ();
   dm_port_arbiter_if b3 ();

`ifdef DM_ARB_PERF_CNT_EN
   logic [31:0] p1_stall, p1_dma, p0_stall, p0_dma, p3_stall, p3_dma;
`endif

   dm_port_arbiter #(.WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .reset(rst1), .bus(b1)
`ifdef DM_ARB_PERF_CNT_EN
      , .perf_cpu_stall_cnt(p1_stall), .perf_dma_grant_cnt(p1_dma)
`endif
   );

   dm_port_arbiter #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(rst0), .bus(b0)
`ifdef DM_ARB_PERF_CNT_EN
      , .perf_cpu_stall_cnt(p0_stall), .perf_dma_grant_cnt(p0_dma)
`endif
   );

   dm_port_arbiter #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset(rst3), .bus(b3)
`ifdef DM_ARB_PERF_CNT_EN
      , .perf_cpu_stall_cnt(p3_stall), .perf_dma_grant_cnt(p3_dma)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (b1.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got %h exp %h", b1.cpu_rdata, 32'h0); end
      checks++; if (b1.dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_dma_rdata got %h exp %h", b1.dma_rdata, 32'h0); end
      checks++; if ({b1.cpu_done, b1.dma_ack, b1.cpu_stall} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {b1.cpu_done, b1.dma_ack, b1.cpu_stall}); end
      checks++; if (b1.m_data_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", b1.m_data_addr, 32'h0); end
      checks++; if (b1.m_data_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp %h", b1.m_data_wdata, 32'h0); end
      checks++; if (b1.m_data_byteen !== 4'h0) begin errors++; $display("FAIL reset_byteen got %b exp 0000", b1.m_data_byteen); end
   endtask

   task automatic test_cpu_read();
      tick();
      b1.cpu_req = 1'b1; b1.cpu_addr = 32'h0000_1006; b1.cpu_byteen = 4'b0000;
      b1.m_data_rdata = 32'hDEAD_BEEF;
      #1;
      checks++; if (b1.cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_t0 got %b exp 1", b1.cpu_stall); end
      tick(); #1;
      checks++; if (b1.m_data_addr !== 32'h0000_1004) begin errors++; $display("FAIL rd_addr got %h exp %h", b1.m_data_addr, 32'h0000_1004); end
      checks++; if (b1.cpu_stall !== 1'b1) begin errors++; $display("FAIL rd_stall_t1 got %b exp 1", b1.cpu_stall); end
      tick(); #1;
      checks++; if ({b1.cpu_stall, b1.cpu_done} !== 2'b10) begin errors++; $display("FAIL rd_t2 got %b exp 10", {b1.cpu_stall, b1.cpu_done}); end
      tick(); #1;
      checks++; if ({b1.cpu_stall, b1.cpu_done} !== 2'b01) begin errors++; $display("FAIL rd_t3 got %b exp 01", {b1.cpu_stall, b1.cpu_done}); end
      checks++; if (b1.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h exp %h", b1.cpu_rdata, 32'hDEAD_BEEF); end
      b1.cpu_req = 1'b0;
      tick(); #1;
      checks++; if (b1.cpu_done !== 1'b0) begin errors++; $display("FAIL rd_t4_done got %b exp 0", b1.cpu_done); end
   endtask

   task automatic test_cpu_write();
      logic [3:0] exp_be;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         if (i == 0) begin
            b1.cpu_req = 1'b1; b1.cpu_addr = 32'h0000_2002; b1.cpu_byteen = 4'b0100;
            b1.cpu_wdata = 32'h00AB_0000; b1.m_data_rdata = 32'h5555_5555;
         end
         #1;
         exp_be = (i == 2) ? 4'b0100 : 4'b0000;
         checks++; if (b1.m_data_byteen !== exp_be) begin errors++; $display("FAIL wr_byteen cyc %0d got %b exp %b", i, b1.m_data_byteen, exp_be); end
         if (i == 2) begin
            checks++; if (b1.m_data_wdata !== 32'h00AB_0000) begin errors++; $display("FAIL wr_wdata got %h exp %h", b1.m_data_wdata, 32'h00AB_0000); end
            checks++; if (b1.m_data_addr !== 32'h0000_2000) begin errors++; $display("FAIL wr_addr got %h exp %h", b1.m_data_addr, 32'h0000_2000); end
         end
         if (i == 3) begin
            checks++; if (b1.cpu_done !== 1'b1) begin errors++; $display("FAIL wr_done got %b exp 1", b1.cpu_done); end
            checks++; if (b1.cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rdata_kept got %h exp %h", b1.cpu_rdata, 32'hDEAD_BEEF); end
            b1.cpu_req = 1'b0; b1.cpu_byteen = 4'b0000;
         end
      end
   endtask

   task automatic test_round_robin();
      logic exp_done, exp_ack;
      tick(); rst1 = 1'b1;
      tick(); rst1 = 1'b0;
      b1.cpu_req = 1'b1; b1.cpu_addr = 32'h0000_0040; b1.cpu_byteen = 4'b0000;
      b1.dma_req = 1'b1; b1.dma_addr = 32'h0000_0020; b1.dma_byteen = 4'b0000;
      b1.m_data_rdata = 32'h0BAD_F00D;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) tick();
         #1;
         exp_done = (i == 3) || (i == 11);
         exp_ack  = (i == 7);
         checks++; if ({b1.cpu_done, b1.dma_ack} !== {exp_done, exp_ack}) begin errors++; $display("FAIL rr_pulse cyc %0d got %b exp %b", i, {b1.cpu_done, b1.dma_ack}, {exp_done, exp_ack}); end
         if (i == 1 || i == 9) begin
            checks++; if (b1.m_data_addr !== 32'h0000_0040) begin errors++; $display("FAIL rr_cpu_addr cyc %0d got %h exp %h", i, b1.m_data_addr, 32'h0000_0040); end
         end
         if (i == 5) begin
            checks++; if (b1.m_data_addr !== 32'h0000_0020) begin errors++; $display("FAIL rr_dma_addr got %h exp %h", b1.m_data_addr, 32'h0000_0020); end
         end
      end
      tick();
      b1.cpu_req = 1'b0; b1.dma_req = 1'b0;
      tick(); #1;
      checks++; if ({b1.cpu_done, b1.dma_ack, b1.m_data_byteen} !== 6'b0) begin errors++; $display("FAIL rr_quiet got %b exp 000000", {b1.cpu_done, b1.dma_ack, b1.m_data_byteen}); end
   endtask

   task automatic test_zero_wait_dma();
      tick();
      b0.cpu_req = 1'b1; b0.cpu_addr = 32'h0000_0008; b0.cpu_byteen = 4'b0000;
      b0.m_data_rdata = 32'hCAFE_F00D;
      tick(); tick(); #1;
      checks++; if (b0.cpu_done !== 1'b1) begin errors++; $display("FAIL w0_cpu_done got %b exp 1", b0.cpu_done); end
      b0.cpu_req = 1'b0;
      tick();
      b0.dma_req = 1'b1; b0.dma_addr = 32'h0000_0010; b0.dma_byteen = 4'b0000;
      b0.m_data_rdata = 32'h1234_5678;
      #1;
      checks++; if (b0.dma_ack !== 1'b0) begin errors++; $display("FAIL w0_ack_t0 got %b exp 0", b0.dma_ack); end
      tick(); #1;
      checks++; if (b0.m_data_addr !== 32'h0000_0010) begin errors++; $display("FAIL w0_addr got %h exp %h", b0.m_data_addr, 32'h0000_0010); end
      checks++; if (b0.dma_ack !== 1'b0) begin errors++; $display("FAIL w0_ack_t1 got %b exp 0", b0.dma_ack); end
      tick(); #1;
      checks++; if (b0.dma_ack !== 1'b1) begin errors++; $display("FAIL w0_ack_t2 got %b exp 1", b0.dma_ack); end
      checks++; if (b0.dma_rdata !== 32'h1234_5678) begin errors++; $display("FAIL w0_dma_rdata got %h exp %h", b0.dma_rdata, 32'h1234_5678); end
      checks++; if (b0.cpu_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL w0_cpu_rdata got %h exp %h", b0.cpu_rdata, 32'hCAFE_F00D); end
      b0.dma_req = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      tick();
      b3.dma_req = 1'b1; b3.dma_addr = 32'h0000_0200; b3.dma_wdata = 32'hFFFF_FFFF;
      b3.dma_byteen = 4'b1111; b3.m_data_rdata = 32'h7777_7777;
      #1;
      checks++; if (b3.m_data_byteen !== 4'b0000) begin errors++; $display("FAIL rm_be_t0 got %b exp 0000", b3.m_data_byteen); end
      tick(); #1;
      checks++; if ({b3.m_data_byteen, b3.dma_ack} !== 5'b0) begin errors++; $display("FAIL rm_t1 got %b exp 00000", {b3.m_data_byteen, b3.dma_ack}); end
      tick();
      rst3 = 1'b1; b3.dma_req = 1'b0;
      #1;
      checks++; if (b3.m_data_byteen !== 4'b0000) begin errors++; $display("FAIL rm_be_t2 got %b exp 0000", b3.m_data_byteen); end
      tick();
      rst3 = 1'b0;
      b3.cpu_req = 1'b1; b3.cpu_addr = 32'h0000_0100; b3.cpu_byteen = 4'b0000;
      b3.dma_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         #1;
         checks++; if ({b3.m_data_byteen, b3.dma_ack} !== 5'b0) begin errors++; $display("FAIL rm_after cyc %0d got %b exp 00000", i, {b3.m_data_byteen, b3.dma_ack}); end
         if (i == 1) begin
            checks++; if (b3.m_data_addr !== 32'h0000_0100) begin errors++; $display("FAIL rm_cpu_first got %h exp %h", b3.m_data_addr, 32'h0000_0100); end
         end
         if (i == 5) begin
            checks++; if (b3.cpu_done !== 1'b1) begin errors++; $display("FAIL rm_cpu_done got %b exp 1", b3.cpu_done); end
         end
      end
      b3.cpu_req = 1'b0; b3.dma_req = 1'b0;
   endtask

`ifdef DM_ARB_PERF_CNT_EN
   task automatic test_perf_counters();
      int dones;
      dones = 0;
      tick(); rst1 = 1'b1;
      tick(); rst1 = 1'b0;
      b1.cpu_req = 1'b1; b1.cpu_addr = 32'h0000_0004; b1.cpu_byteen = 4'b0000;
      #1;
      checks++; if (p1_stall !== 32'd0) begin errors++; $display("FAIL perf_clear got %0d exp 0", p1_stall); end
      for (int i = 0; i < 40 && dones < 4; i++) begin
         if (i > 0) begin tick(); #1; end
         if (b1.cpu_done === 1'b1) dones++;
      end
      checks++; if (dones !== 4) begin errors++; $display("FAIL perf_done_count got %0d exp 4", dones); end
      checks++; if (p1_stall !== 32'd12) begin errors++; $display("FAIL perf_stall_cnt got %0d exp 12", p1_stall); end
      checks++; if (p1_dma !== 32'd0) begin errors++; $display("FAIL perf_dma_cnt got %0d exp 0", p1_dma); end
      b1.cpu_req = 1'b0;
      tick(); #1;
      checks++; if (p1_stall !== 32'd12) begin errors++; $display("FAIL perf_stall_hold got %0d exp 12", p1_stall); end
   endtask
`endif

   task automatic init_bus();
      b1.cpu_req = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0; b1.cpu_byteen = 0;
      b1.dma_req = 0; b1.dma_addr = 0; b1.dma_wdata = 0; b1.dma_byteen = 0; b1.m_data_rdata = 0;
      b0.cpu_req = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0; b0.cpu_byteen = 0;
      b0.dma_req = 0; b0.dma_addr = 0; b0.dma_wdata = 0; b0.dma_byteen = 0; b0.m_data_rdata = 0;
      b3.cpu_req = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0; b3.cpu_byteen = 0;
      b3.dma_req = 0; b3.dma_addr = 0; b3.dma_wdata = 0; b3.dma_byteen = 0; b3.m_data_rdata = 0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst1 = 1'b1; rst0 = 1'b1; rst3 = 1'b1;
      init_bus();
      tick(); tick();
      rst1 = 1'b0; rst0 = 1'b0; rst3 = 1'b0;
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_round_robin();
      test_zero_wait_dma();
      test_reset_mid_access();
`ifdef DM_ARB_PERF_CNT_EN
      test_perf_counters();
`endif
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
